// File: rtl/regfile_writeback.sv
// Write-back arbiter for the 8x16 register file: ALU results take priority, memory returns queue in a FIFO.
// Optional feature: define ZERO_REG_EN to hard-wire register 0 to zero (writes to it are suppressed).
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [2:0]    alu_reg,
    input  logic [15:0]   alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [2:0]    mem_reg,
    input  logic [15:0]   mem_data,
    output logic          write,
    output logic [2:0]    wreg,
    output logic [15:0]   wd,
    output logic [7:0]    pending,
    output logic [AW:0]   fifo_cnt
);

    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);

    logic [2:0]  fifo_reg  [DEPTH];
    logic [15:0] fifo_data [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [AW:0]   cnt [8];

    logic        push;
    logic        pop;
    logic [2:0]  head_reg;
    logic [15:0] head_data;
    logic        alu_wr;
    logic        mem_wr;
    logic        push_tracked;
    logic [7:0]  inc_vec;
    logic [7:0]  dec_vec;

    assign mem_ready = (count != FULL);
    assign fifo_cnt  = count;
    assign push      = mem_valid && mem_ready;
    assign pop       = !alu_valid && (count != '0);
    assign head_reg  = fifo_reg[head];
    assign head_data = fifo_data[head];

    // Register 0 entries still occupy a FIFO slot and a pop cycle, but never write or track pending.
`ifdef ZERO_REG_EN
    assign alu_wr       = alu_valid && (alu_reg != 3'd0);
    assign mem_wr       = pop && (head_reg != 3'd0);
    assign push_tracked = push && (mem_reg != 3'd0);
`else
    assign alu_wr       = alu_valid;
    assign mem_wr       = pop;
    assign push_tracked = push;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[tail]  <= mem_reg;
            fifo_data[tail] <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write <= 1'b0;
            wreg  <= '0;
            wd    <= '0;
        end else begin
            write <= alu_wr || mem_wr;
            if (alu_wr) begin
                wreg <= alu_reg;
                wd   <= alu_data;
            end else if (mem_wr) begin
                wreg <= head_reg;
                wd   <= head_data;
            end
        end
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (push_tracked) inc_vec[mem_reg]  = 1'b1;
        if (mem_wr)       dec_vec[head_reg] = 1'b1;
    end

    // A push and pop naming the same register cancel out, leaving its count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 8; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 8; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + CNT_ONE;
                else if (dec_vec[r] && !inc_vec[r])
                    cnt[r] <= cnt[r] - CNT_ONE;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 0; r < 8; r++) pending[r] = (cnt[r] != '0);
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a queue-based model predicts writes, a monitor checks them.
// Honours ZERO_REG_EN when the build defines it.
module tb_regfile_writeback;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] d;
    } wb_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [2:0]    alu_reg;
    logic [15:0]   alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [2:0]    mem_reg;
    logic [15:0]   mem_data;
    logic          write;
    logic [2:0]    wreg;
    logic [15:0]   wd;
    logic [7:0]    pending;
    logic [AW:0]   fifo_cnt;

    wb_t model_q[$];
    wb_t exp_q[$];
    int  total_checks = 0;
    int  passed_checks = 0;
    bit  checking = 1'b0;

    regfile_writeback #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .write     (write),
        .wreg      (wreg),
        .wd        (wd),
        .pending   (pending),
        .fifo_cnt  (fifo_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit is_dropped(input logic [2:0] r);
`ifdef ZERO_REG_EN
        return (r == 3'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] model_pending();
        logic [7:0] p = '0;
        foreach (model_q[i])
            if (!is_dropped(model_q[i].r)) p[model_q[i].r] = 1'b1;
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        total_checks++;
        if (act_v === exp_v)
            passed_checks++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act_v, exp_v, $time);
    endtask

    // One cycle of stimulus; the model predicts the write and queue state after the coming edge.
    task automatic applyStimulus(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                                 input logic mv, input logic [2:0] mr, input logic [15:0] md);
        bit accept;
        wb_t e;
        @(negedge clk);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        accept = mv && (model_q.size() < DEPTH);
        if (av) begin
            if (!is_dropped(ar)) exp_q.push_back('{r: ar, d: ad});
        end else if (model_q.size() > 0) begin
            e = model_q.pop_front();
            if (!is_dropped(e.r)) exp_q.push_back(e);
        end
        if (accept) model_q.push_back('{r: mr, d: md});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    endtask

    initial begin : monitor
        wb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (checking) begin
                if (write) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_write", {29'd0, wreg}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("wreg", {29'd0, wreg}, {29'd0, e.r});
                        checkOutput("wd", {16'd0, wd}, {16'd0, e.d});
                    end
                end else begin
                    checkOutput("missed_write", exp_q.size(), 0);
                end
                checkOutput("fifo_cnt", {29'd0, fifo_cnt}, model_q.size());
                checkOutput("pending", {24'd0, pending}, {24'd0, model_pending()});
                checkOutput("mem_ready", {31'd0, mem_ready}, {31'd0, (model_q.size() != DEPTH)});
            end
        end
    end

    task automatic doReset();
        @(posedge clk);
        #2;
        checking = 1'b0;
        rst = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        #1;
        checkOutput("rst_write", {31'd0, write}, 32'd0);
        checkOutput("rst_pending", {24'd0, pending}, 32'd0);
        checkOutput("rst_fifo_cnt", {29'd0, fifo_cnt}, 32'd0);
        model_q.delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
    endtask

    initial begin : stimulus
        int alu_pct;
        rst = 1'b1;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        #1;
        checkOutput("init_write", {31'd0, write}, 32'd0);
        checkOutput("init_wreg", {29'd0, wreg}, 32'd0);
        checkOutput("init_wd", {16'd0, wd}, 32'd0);
        checkOutput("init_pending", {24'd0, pending}, 32'd0);
        checkOutput("init_fifo_cnt", {29'd0, fifo_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;

        $display("[TB] ALU-only write");
        applyStimulus(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 16'd0);
        idle(2);

        $display("[TB] Mem-only write");
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 16'h1234);
        idle(3);

        $display("[TB] Full FIFO under ALU pressure");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 3'(i + 1), 16'($urandom), 1'b1, 3'(i + 2), 16'h1000 + 16'(i));
        applyStimulus(1'b1, 3'd7, 16'hAAAA, 1'b1, 3'd1, 16'h2222);
        idle(6);

        $display("[TB] Same-register queueing");
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 3'd2, 16'h0001);
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 3'd2, 16'h0002);
        idle(4);
        checkOutput("final_wd", {16'd0, wd}, 32'h0000_0002);

        $display("[TB] Write to register 0");
        applyStimulus(1'b1, 3'd0, 16'h55AA, 1'b0, 3'd0, 16'd0);
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 3'd0, 16'h0BAD);
        idle(3);

        $display("[TB] Reset mid-operation");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 3'd6, 16'h3000 + 16'(i), 1'b1, 3'(i + 4), 16'h4000 + 16'(i));
        applyStimulus(1'b1, 3'd6, 16'h3003, 1'b0, 3'd0, 16'd0);
        doReset();
        idle(3);

        $display("[TB] Randomized traffic");
        alu_pct = 40;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) alu_pct = int'($urandom_range(0, 95));
            applyStimulus($urandom_range(0, 99) < alu_pct, 3'($urandom), 16'($urandom),
                          $urandom_range(0, 99) < 60, 3'($urandom), 16'($urandom));
        end
        idle(DEPTH + 4);
        checkOutput("scoreboard_drain", exp_q.size(), 0);
        checkOutput("model_drain", model_q.size(), 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
